// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl: store buffer and miss sequencer below the write-through D-cache.
// Optional macro WB_FWD_EN: forward buffered stores to misses; misses bypass the buffer.
module cache_mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    output logic                  fill_valid,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int WA = ADDR_WIDTH - 2;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] FILL  = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_nx;
    logic [WA-1:0]         fifo_addr [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [PW:0]           count;
    logic                  miss_pending;
    logic [WA-1:0]         miss_addr_q;
    logic [DATA_WIDTH-1:0] fill_q;
    logic                  fwd_valid;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  miss_hs;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  rd_ok;
    logic                  want_rd;
    logic                  unused_lsbs;

    // Byte offsets never reach memory; words only.
    assign unused_lsbs = ^{wr_addr[1:0], miss_addr[1:0]};

    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign wr_ready   = !full;
    assign miss_ready = !miss_pending;
    assign push       = wr_valid && !full;
    assign pop        = (state == WRITE) && mem_ack;
    assign miss_hs    = miss_valid && !miss_pending;
    assign want_rd    = miss_pending || (miss_hs && !fwd_hit);

`ifdef WB_FWD_EN
    logic [PW-1:0] fwd_idx;
    logic          fwd_match;

    // Youngest buffered (or same-cycle) store to the missed word wins.
    always_comb begin
        fwd_match = 1'b0;
        fwd_data  = '0;
        fwd_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rptr + PW'(i);
            if (((PW+1)'(i) < count) &&
                (fifo_addr[fwd_idx] == miss_addr[ADDR_WIDTH-1:2])) begin
                fwd_match = 1'b1;
                fwd_data  = fifo_data[fwd_idx];
            end
        end
        if (push && (wr_addr[ADDR_WIDTH-1:2] == miss_addr[ADDR_WIDTH-1:2])) begin
            fwd_match = 1'b1;
            fwd_data  = wr_data;
        end
    end

    assign fwd_hit = miss_hs && fwd_match;
    assign rd_ok   = 1'b1;
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
    assign rd_ok    = empty && !push;
`endif

    // Write buffer pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Write buffer storage; contents are meaningless until counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wptr] <= wr_addr[ADDR_WIDTH-1:2];
            fifo_data[wptr] <= wr_data;
        end
    end

    // Single outstanding miss; released once memory answers the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_pending <= 1'b0;
            miss_addr_q  <= '0;
        end else if (miss_hs && !fwd_hit) begin
            miss_pending <= 1'b1;
            miss_addr_q  <= miss_addr[ADDR_WIDTH-1:2];
        end else if ((state == READ) && mem_ack) begin
            miss_pending <= 1'b0;
        end
    end

    // Fill word: from memory on a read, or from the buffer on a forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q    <= '0;
            fwd_valid <= 1'b0;
        end else begin
            fwd_valid <= fwd_hit;
            if (fwd_hit)                        fill_q <= fwd_data;
            else if ((state == READ) && mem_ack) fill_q <= mem_rdata;
        end
    end

    // Sequencer: pending read beats queued writes only when allowed.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (want_rd && rd_ok) state_nx = READ;
                else if (!empty)      state_nx = WRITE;
            end
            WRITE:   if (mem_ack) state_nx = IDLE;
            READ:    if (mem_ack) state_nx = FILL;
            FILL:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Memory port driven purely from state so it holds until acked.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {fifo_addr[rptr], 2'b00};
                mem_wdata = fifo_data[rptr];
            end
            READ: begin
                mem_req  = 1'b1;
                mem_addr = {miss_addr_q, 2'b00};
            end
            default: ;
        endcase
    end

    assign fill_valid = (state == FILL) || fwd_valid;
    assign fill_data  = fill_q;
    assign busy       = !empty || miss_pending || fwd_valid || (state != IDLE);

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// tb_cache_mem_ctrl: scenario tasks plus a memory responder and a coherence model.
// The model predicts each fill as the youngest accepted store to that word, else memory.
module tb_cache_mem_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        miss_valid = 1'b0;
    logic        miss_ready;
    logic [31:0] miss_addr = '0;
    logic        fill_valid;
    logic [31:0] fill_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;

    cache_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .miss_valid(miss_valid), .miss_ready(miss_ready),
        .miss_addr(miss_addr),
        .fill_valid(fill_valid), .fill_data(fill_data),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } st_t;

    st_t         sq[$];
    logic [31:0] exp_fill[$];
    logic [31:0] mem [logic [29:0]];

    int n_chk = 0;
    int n_fail = 0;
    int fixed_lat = -1;
    bit force_ack = 1'b0;
    int wcnt = -1;

    logic        p_req = 1'b0;
    logic        p_ack = 1'b0;
    logic        p_we = 1'b0;
    logic [31:0] p_addr = '0;
    logic [31:0] p_wdata = '0;

    function automatic logic [31:0] mem_rd(logic [29:0] w);
        if (mem.exists(w)) return mem[w];
        return {2'b00, w} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] expect_read(logic [29:0] w);
        logic [31:0] v;
        v = mem_rd(w);
        foreach (sq[i]) if (sq[i].addr[31:2] == w) v = sq[i].data;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Main memory: acks after a latency, reads return current contents.
    always @(posedge clk) begin
        #1;
        if (force_ack) begin
            mem_ack = 1'b1;
        end else if (rst || !mem_req || mem_ack) begin
            mem_ack = 1'b0;
            wcnt = -1;
        end else begin
            if (wcnt < 0) wcnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            if (wcnt == 0) begin
                mem_ack = 1'b1;
                mem_rdata = mem_rd(mem_addr[31:2]);
            end else begin
                wcnt--;
            end
        end
    end

    // Protocol and ordering monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            sq.delete();
            exp_fill.delete();
            p_req = 1'b0;
            p_ack = 1'b0;
        end else begin
            if (p_req && !p_ack) begin
                n_chk++;
                if (mem_req !== 1'b1 || mem_we !== p_we ||
                    mem_addr !== p_addr || mem_wdata !== p_wdata) begin
                    n_fail++;
                    $display("FAIL req_stable: got req=%b we=%b a=%h d=%h want a=%h d=%h",
                             mem_req, mem_we, mem_addr, mem_wdata, p_addr, p_wdata);
                end
            end
            if (p_req && p_ack) begin
                n_chk++;
                if (mem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL req_drop: got mem_req=%b want 0", mem_req);
                end
            end
            if (mem_req) begin
                n_chk++;
                if (mem_addr[1:0] !== 2'b00) begin
                    n_fail++;
                    $display("FAIL addr_align: got %h", mem_addr);
                end
            end
`ifndef WB_FWD_EN
            if (mem_req && !mem_we && !p_req) begin
                n_chk++;
                if (sq.size() != 0) begin
                    n_fail++;
                    $display("FAIL read_before_drain: got %0d queued want 0", sq.size());
                end
            end
`endif
            if (mem_req && mem_ack && mem_we) begin
                n_chk++;
                if (sq.size() == 0) begin
                    n_fail++;
                    $display("FAIL write_spurious: got a=%h d=%h want none", mem_addr, mem_wdata);
                end else begin
                    if (mem_addr !== {sq[0].addr[31:2], 2'b00} || mem_wdata !== sq[0].data) begin
                        n_fail++;
                        $display("FAIL write_order: got a=%h d=%h want a=%h d=%h",
                                 mem_addr, mem_wdata, {sq[0].addr[31:2], 2'b00}, sq[0].data);
                    end
                    void'(sq.pop_front());
                end
                mem[mem_addr[31:2]] = mem_wdata;
            end
            if (fill_valid) begin
                n_chk++;
                if (exp_fill.size() == 0) begin
                    n_fail++;
                    $display("FAIL fill_spurious: got %h want no fill", fill_data);
                end else begin
                    if (fill_data !== exp_fill[0]) begin
                        n_fail++;
                        $display("FAIL fill_data: got %h want %h", fill_data, exp_fill[0]);
                    end
                    void'(exp_fill.pop_front());
                end
            end
            if (wr_valid && wr_ready) sq.push_back(st_t'{wr_addr, wr_data});
            if (miss_valid && miss_ready) exp_fill.push_back(expect_read(miss_addr[31:2]));
            n_chk++;
            if (sq.size() > DEPTH) begin
                n_fail++;
                $display("FAIL occupancy: got %0d want <= %0d", sq.size(), DEPTH);
            end
            p_req = mem_req;
            p_ack = mem_ack;
            p_we = mem_we;
            p_addr = mem_addr;
            p_wdata = mem_wdata;
        end
    end

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (!busy && exp_fill.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!ok || sq.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got busy=%b queued=%0d fills=%0d want idle",
                     tag, busy, sq.size(), exp_fill.size());
        end
        tick();
    endtask

    task automatic test_reset();
        bit ok = 1'b0;
        @(negedge clk);
        n_chk++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mem: got req=%b we=%b a=%h d=%h want 0",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        n_chk++;
        if (fill_valid !== 1'b0 || fill_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_fill: got v=%b d=%h want 0", fill_valid, fill_data);
        end
        n_chk++;
        if (wr_ready !== 1'b1 || miss_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got wr=%b miss=%b busy=%b want 1 1 0",
                     wr_ready, miss_ready, busy);
        end
        tick();
        rst = 1'b0;
        tick();
        fixed_lat = 20;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_addr = 32'h300 + 32'(4 * i);
            wr_data = 32'hC0 + 32'(i);
            tick();
        end
        wr_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!ok || mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_write: got req=%b we=%b want 1 1", mem_req, mem_we);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_chk++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_async: got req=%b busy=%b wr_ready=%b want 0 0 1",
                     mem_req, busy, wr_ready);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        force_ack = 1'b1;
        @(posedge clk);
        #2;
        force_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_chk++;
            if (busy !== 1'b0 || mem_req !== 1'b0 || fill_valid !== 1'b0 || wr_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_late_ack: got busy=%b req=%b fill=%b wr_ready=%b want 0 0 0 1",
                         busy, mem_req, fill_valid, wr_ready);
            end
        end
        fixed_lat = -1;
        tick();
    endtask

    task automatic test_full();
        bit ok = 1'b0;
        fixed_lat = 5;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_addr = 32'h100 + 32'(4 * i);
            wr_data = 32'hA0 + 32'(i);
            @(negedge clk);
            n_chk++;
            if (wr_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_up_%0d: got wr_ready=%b want 1", i, wr_ready);
            end
            tick();
        end
        wr_addr = 32'h110;
        wr_data = 32'hA4;
        @(negedge clk);
        n_chk++;
        if (wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_flag: got wr_ready=%b want 0", wr_ready);
        end
        for (int k = 0; k < 30; k++) begin
            if (mem_req && mem_ack && mem_we) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_chk++;
        if (!ok || wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pop_push: got ack=%b wr_ready=%b want 1 0", ok, wr_ready);
        end
        @(negedge clk);
        n_chk++;
        if (wr_ready !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL after_pop: got wr_ready=%b req=%b want 1 0", wr_ready, mem_req);
        end
        tick();
        wr_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h104 || mem_wdata !== 32'hA1) begin
            n_fail++;
            $display("FAIL one_idle_gap: got req=%b a=%h d=%h want 1 104 a1",
                     mem_req, mem_addr, mem_wdata);
        end
        wait_idle("full");
        fixed_lat = -1;
    endtask

    task automatic test_fill_basic();
        bit ok = 1'b0;
        mem[30'h80] = 32'hDEAD_BEEF;
        fixed_lat = 3;
        miss_valid = 1'b1;
        miss_addr = 32'h203;
        @(negedge clk);
        n_chk++;
        if (miss_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL miss_accept: got miss_ready=%b want 1", miss_ready);
        end
        tick();
        miss_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL miss_read: got req=%b we=%b a=%h want 1 0 200",
                     mem_req, mem_we, mem_addr);
        end
        for (int k = 0; k < 20; k++) begin
            if (mem_req && mem_ack) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        n_chk++;
        if (!ok || fill_valid !== 1'b1 || fill_data !== 32'hDEAD_BEEF || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_timing: got v=%b d=%h req=%b want 1 deadbeef 0",
                     fill_valid, fill_data, mem_req);
        end
        @(negedge clk);
        n_chk++;
        if (fill_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_pulse: got v=%b want 0", fill_valid);
        end
        fixed_lat = -1;
        wait_idle("fill");
    endtask

`ifndef WB_FWD_EN
    task automatic test_raw_order();
        bit wrote = 1'b0;
        bit done = 1'b0;
        fixed_lat = 2;
        wr_valid = 1'b1;
        wr_addr = 32'h40;
        wr_data = 32'h11;
        tick();
        wr_valid = 1'b0;
        miss_valid = 1'b1;
        miss_addr = 32'h40;
        tick();
        miss_valid = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (mem_req && !mem_we && !p_req) begin
                n_chk++;
                if (!wrote) begin
                    n_fail++;
                    $display("FAIL raw_read_first: got read before write want write first");
                end
            end
            if (mem_req && mem_we && mem_ack && mem_addr == 32'h40) wrote = 1'b1;
            if (fill_valid) begin
                done = 1'b1;
                n_chk++;
                if (fill_data !== 32'h11) begin
                    n_fail++;
                    $display("FAIL raw_fill: got %h want 11", fill_data);
                end
                break;
            end
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL raw_timeout: got no fill want fill");
        end
        fixed_lat = -1;
        wait_idle("raw");
    endtask
`else
    task automatic test_forward();
        bit read_seen = 1'b0;
        fixed_lat = 6;
        wr_valid = 1'b1;
        wr_addr = 32'h40;
        wr_data = 32'h11;
        tick();
        wr_data = 32'h22;
        tick();
        wr_valid = 1'b0;
        miss_valid = 1'b1;
        miss_addr = 32'h40;
        tick();
        miss_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (fill_valid !== 1'b1 || fill_data !== 32'h22) begin
            n_fail++;
            $display("FAIL fwd_fill: got v=%b d=%h want 1 22", fill_valid, fill_data);
        end
        for (int k = 0; k < 40 && busy; k++) begin
            @(negedge clk);
            if (mem_req && !mem_we) read_seen = 1'b1;
        end
        n_chk++;
        if (read_seen) begin
            n_fail++;
            $display("FAIL fwd_no_read: got read request want none");
        end
        wait_idle("fwd");
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_addr = 32'h500 + 32'(4 * i);
            wr_data = 32'h70 + 32'(i);
            tick();
        end
        wr_valid = 1'b0;
        miss_valid = 1'b1;
        miss_addr = 32'h80;
        tick();
        miss_valid = 1'b0;
        read_seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (mem_req && !mem_we) begin
                read_seen = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!read_seen || sq.size() == 0) begin
            n_fail++;
            $display("FAIL fwd_bypass: got read=%b queued=%0d want 1 >0", read_seen, sq.size());
        end
        fixed_lat = -1;
        wait_idle("bypass");
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            miss_valid = ($urandom_range(0, 3) == 0);
            miss_addr = 32'h40 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            wr_valid = (exp_fill.size() == 0) && ($urandom_range(0, 1) == 1);
            wr_addr = 32'h40 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            wr_data = $urandom;
            tick();
        end
        wr_valid = 1'b0;
        miss_valid = 1'b0;
        wait_idle("random");
    endtask

    initial begin
        test_reset();
        test_full();
        test_fill_basic();
`ifndef WB_FWD_EN
        test_raw_order();
`else
        test_forward();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_mem_ctrl.md
Name: cache_mem_ctrl

Overview:
- Memory-side controller directly downstream of the direct-mapped, write-through data cache.
- Accepts write-through stores and read-miss fill requests from the cache, and buffers stores in a FIFO.
- Drains stores to main memory over a single req/ack port and returns fill words to the cache.
- Guarantees that a miss fill never returns data older than a store the cache issued before it.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, word width
DEPTH, 4, write buffer entries (power of 2, >= 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
wr_valid  in  1  cache presents a write-through store
wr_ready  out  1  store accepted when wr_valid && wr_ready
wr_addr  in  ADDR_WIDTH  store byte address
wr_data  in  DATA_WIDTH  store word
miss_valid  in  1  cache requests line fill
miss_ready  out  1  miss accepted when miss_valid && miss_ready
miss_addr  in  ADDR_WIDTH  miss byte address
fill_valid  out  1  one-cycle pulse, fill_data valid
fill_data  out  DATA_WIDTH  returned word
mem_req  out  1  memory request, held until acked
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_WIDTH  word-aligned address, [1:0] forced 0
mem_wdata  out  DATA_WIDTH  write data
mem_ack  in  1  memory completes request this cycle
mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack
busy  out  1  FIFO non-empty, or miss outstanding, or request in flight

Behaviour:
- Reset (async, immediate): FIFO emptied (pointers and count 0), miss slot cleared, state IDLE. Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, fill_valid=0, fill_data=0, wr_ready=1, miss_ready=1, busy=0. An in-flight memory request is abandoned; a late mem_ack is ignored.
- Write FIFO:
  - wr_ready = !full, using the registered count.
  - When full, a same-cycle pop does not enable a push.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
- Miss slot:
  - One outstanding miss; miss_ready = !miss_pending.
  - The miss address is latched on handshake.
  - A store accepted in the same cycle as a miss handshake is older than the miss.
- FSM states: IDLE, WRITE, READ, FILL.
  - IDLE: if the miss is pending and the read is permitted -> READ. Otherwise, if the FIFO is non-empty -> WRITE with the head entry. Otherwise stay.
  - Read permitted (no WB_FWD_EN) = FIFO empty and no push this cycle.
  - WRITE: mem_req=1, mem_we=1, head addr/data stable. On mem_ack: pop the head, return to IDLE. mem_req=0 in the following cycle.
  - READ: mem_req=1, mem_we=0, mem_addr = miss addr with [1:0]=0. On mem_ack: capture mem_rdata -> FILL.
  - FILL: fill_valid=1 for exactly one cycle, fill_data = captured word, miss slot cleared (miss_ready=1 this cycle) -> IDLE.
- Latency, empty FIFO: miss handshake in cycle N; mem_req=1 from N+1. mem_ack in cycle M -> fill_valid in M+1, mem_req=0 in M+1.
- Write drain: entry at head in cycle N with the FSM IDLE -> mem_req from N+1. Back-to-back writes have one IDLE cycle between requests.
- mem_ack while mem_req=0 is ignored. Request signals never change while mem_req=1 and mem_ack=0.
- Stores continue to be accepted while READ is in progress. Reads have priority over queued writes only when permitted.

Optional Feature:
WB_FWD_EN
- Defined:
  - On miss handshake, miss_addr[ADDR_WIDTH-1:2] is compared against all valid FIFO entries and a same-cycle pushed store.
  - On a match, the youngest match wins. fill_valid is asserted in N+1 with that data and no memory read is made.
  - On no match, the read is permitted immediately (after any in-flight WRITE completes), bypassing queued stores.
- Undefined: no comparators. Reads wait for the FIFO to fully drain, per the rule above.

Test Plan:
- Reset mid-WRITE (mem_req=1, 3 entries queued) -> same-cycle mem_req=0, busy=0, wr_ready=1; a mem_ack the next cycle causes no pop or fill.
- Push 4 stores (0x100..0x10C, data 0xA0..0xA3) with mem_ack delayed 5 cycles -> wr_ready=0 after the 4th; memory sees 4 writes in order with addr/data stable during each wait.
- Empty FIFO, miss 0x203 -> mem_addr=0x200, mem_we=0; mem_ack with rdata 0xDEADBEEF in cycle M -> fill_valid=1 in M+1 with fill_data=0xDEADBEEF, one cycle only.
- Without WB_FWD_EN: store 0x40=0x11 queued, then miss 0x40 -> the write completes before mem_req read; memory returns 0x11; fill_data=0x11.
- With WB_FWD_EN: stores 0x40=0x11 then 0x40=0x22 queued, miss 0x40 -> fill_valid next cycle with 0x22 and no read request. Miss 0x80 -> read issued before the queued writes drain.
- Full FIFO, push attempt in the same cycle as a pop -> push not accepted; the entry is accepted the next cycle; count never exceeds DEPTH.
